// File: rtl/decoder_seq_if.sv
// Bus bundle for decoder_seq: control/select inputs and the registered decode outputs.
// The master drives EN/MODE/LD/A; the slave (decoder) drives D/IDX/VALID/WRAP.
interface decoder_seq_if #(
    parameter int N = 2
);
    logic            EN;
    logic            MODE;
    logic            LD;
    logic [N-1:0]    A;
    logic [2**N-1:0] D;
    logic [N-1:0]    IDX;
    logic            VALID;
    logic            WRAP;

    modport master (
        output EN, MODE, LD, A,
        input  D, IDX, VALID, WRAP
    );

    modport slave (
        input  EN, MODE, LD, A,
        output D, IDX, VALID, WRAP
    );
endinterface

// File: rtl/decoder_seq.sv
// Sequenced one-hot decoder: holds, loads or auto-scans an N-bit index and
// presents its registered one-hot decode, with a single-cycle pulse on scan wrap-around.
module decoder_seq #(
    parameter int N = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    decoder_seq_if.slave  bus
);
    localparam int W = 2**N;
    localparam logic [N-1:0] IDX_ONE = N'(1'b1);
    localparam logic [N-1:0] IDX_MAX = {N{1'b1}};
    localparam logic [W-1:0] D_ONE   = W'(1'b1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t          state_s;
    logic [N-1:0]    next_idx_s;
    logic            wrap_s;
    logic [N-1:0]    idx_r;
    logic [W-1:0]    d_r;
    logic            valid_r;
    logic            wrap_r;

    function automatic logic [W-1:0] onehot_f(input logic [N-1:0] i);
        return D_ONE << i;
    endfunction

    // State follows EN/MODE directly each cycle; next index and wrap detection.
    always_comb begin
        state_s    = IDLE;
        next_idx_s = idx_r;
        wrap_s     = 1'b0;
        if (bus.EN) begin
            state_s = bus.MODE ? SCAN : HOLD;
        end else begin
            state_s = IDLE;
        end
        case (state_s)
            IDLE: begin
                next_idx_s = idx_r;
            end
            HOLD: begin
                next_idx_s = bus.LD ? bus.A : idx_r;
            end
            SCAN: begin
                if (bus.LD) begin
                    // A load of zero is not a wrap, so only the increment path flags it.
                    next_idx_s = bus.A;
                end else begin
                    next_idx_s = idx_r + IDX_ONE;
                    wrap_s     = (idx_r == IDX_MAX);
                end
            end
            default: begin
                next_idx_s = idx_r;
            end
        endcase
    end

    // Index register and registered decode outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r   <= '0;
            d_r     <= '0;
            valid_r <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            case (state_s)
                IDLE: begin
                    d_r     <= '0;
                    valid_r <= 1'b0;
                    wrap_r  <= 1'b0;
                end
                HOLD, SCAN: begin
                    idx_r   <= next_idx_s;
                    d_r     <= onehot_f(next_idx_s);
                    valid_r <= 1'b1;
                    wrap_r  <= wrap_s;
                end
                default: begin
                    d_r     <= '0;
                    valid_r <= 1'b0;
                    wrap_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.D     = d_r;
    assign bus.IDX   = idx_r;
    assign bus.VALID = valid_r;
    assign bus.WRAP  = wrap_r;
endmodule

// File: tb/tb_decoder_seq.sv
// Directed-vector bench for decoder_seq at N=2, N=3 and N=1 with hand-computed expectations.
module tb_decoder_seq;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    int   wraps;

    decoder_seq_if #(.N(2)) a ();
    decoder_seq_if #(.N(3)) b ();
    decoder_seq_if #(.N(1)) c ();

    decoder_seq #(.N(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(a));
    decoder_seq #(.N(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b));
    decoder_seq #(.N(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic exp2(input string tag, input logic [3:0] d, input logic [1:0] idx,
                        input logic v, input logic w);
        chk({tag, ".D"},     32'(a.D),     32'(d));
        chk({tag, ".IDX"},   32'(a.IDX),   32'(idx));
        chk({tag, ".VALID"}, 32'(a.VALID), 32'(v));
        chk({tag, ".WRAP"},  32'(a.WRAP),  32'(w));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv2(input logic en, input logic mode, input logic ld, input logic [1:0] aval);
        a.EN = en; a.MODE = mode; a.LD = ld; a.A = aval;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        wraps = 0;
        rst_n = 1'b0;
        drv2(1'b0, 1'b0, 1'b0, 2'd0);
        b.EN = 1'b0; b.MODE = 1'b0; b.LD = 1'b0; b.A = 3'd0;
        c.EN = 1'b0; c.MODE = 1'b0; c.LD = 1'b0; c.A = 1'b0;
        #23;
        exp2("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset then hold: load 2, then steady.
        drv2(1'b1, 1'b0, 1'b1, 2'd2); step();
        exp2("hold_ld", 4'b0100, 2'd2, 1'b1, 1'b0);
        drv2(1'b1, 1'b0, 1'b0, 2'd0); step();
        exp2("hold1", 4'b0100, 2'd2, 1'b1, 1'b0);
        step();
        exp2("hold2", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Full scan: load 1 in SCAN, then three increments.
        drv2(1'b1, 1'b1, 1'b1, 2'd1); step();
        exp2("scan0", 4'b0010, 2'd1, 1'b1, 1'b0);
        drv2(1'b1, 1'b1, 1'b0, 2'd0); step();
        exp2("scan1", 4'b0100, 2'd2, 1'b1, 1'b0);
        step();
        exp2("scan2", 4'b1000, 2'd3, 1'b1, 1'b0);
        step();
        exp2("scan3", 4'b0001, 2'd0, 1'b1, 1'b1);

        // Enable drop at IDX=3.
        step(); step(); step();
        exp2("pre_drop", 4'b1000, 2'd3, 1'b1, 1'b0);
        drv2(1'b0, 1'b1, 1'b0, 2'd0); step();
        exp2("idle1", 4'b0000, 2'd3, 1'b0, 1'b0);
        step();
        exp2("idle2", 4'b0000, 2'd3, 1'b0, 1'b0);
        drv2(1'b1, 1'b1, 1'b0, 2'd0); step();
        exp2("resume", 4'b0001, 2'd0, 1'b1, 1'b1);
        step();
        exp2("resume_nx", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Load priority over increment at IDX=1.
        drv2(1'b1, 1'b1, 1'b1, 2'd3); step();
        exp2("ld_pri", 4'b1000, 2'd3, 1'b1, 1'b0);
        drv2(1'b1, 1'b1, 1'b0, 2'd0); step();
        exp2("ld_pri_nx", 4'b0001, 2'd0, 1'b1, 1'b1);

        // Load of 0 from IDX=3 must not pulse WRAP.
        drv2(1'b1, 1'b0, 1'b1, 2'd3); step();
        exp2("ld3", 4'b1000, 2'd3, 1'b1, 1'b0);
        drv2(1'b1, 1'b1, 1'b1, 2'd0); step();
        exp2("ld0_nowrap", 4'b0001, 2'd0, 1'b1, 1'b0);

        // LD ignored while disabled; HOLD resumes from retained index.
        drv2(1'b0, 1'b0, 1'b1, 2'd2); step();
        exp2("ld_dis", 4'b0000, 2'd0, 1'b0, 1'b0);
        drv2(1'b1, 1'b0, 1'b0, 2'd0); step();
        exp2("hold_resume", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-scan at IDX=2.
        drv2(1'b1, 1'b1, 1'b0, 2'd0); step(); step();
        exp2("pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        exp2("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        exp2("rst_held", 4'b0000, 2'd0, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        step();
        exp2("rst_scan", 4'b0010, 2'd1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        drv2(1'b1, 1'b0, 1'b0, 2'd0); step();
        exp2("rst_hold", 4'b0001, 2'd0, 1'b1, 1'b0);

        // N=3 sweep from 0.
        b.EN = 1'b1; b.MODE = 1'b1; b.LD = 1'b1; b.A = 3'd0; step();
        chk("n3_ld.D", 32'(b.D), 32'h01);
        chk("n3_ld.WRAP", 32'(b.WRAP), 32'd0);
        b.LD = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("n3.D", 32'(b.D), 32'(8'(8'h01 << (i % 8))));
            chk("n3.onehot", 32'($onehot(b.D)), 32'd1);
            chk("n3.WRAP", 32'(b.WRAP), (i == 8) ? 32'd1 : 32'd0);
            if (b.WRAP) wraps = wraps + 1;
        end
        chk("n3.wraps", 32'(wraps), 32'd1);
        b.EN = 1'b0;

        // N=1 toggle with WRAP on every 1->0 step.
        c.EN = 1'b1; c.MODE = 1'b1; c.LD = 1'b0; step();
        chk("n1_a.IDX", 32'(c.IDX), 32'd1);
        chk("n1_a.WRAP", 32'(c.WRAP), 32'd0);
        step();
        chk("n1_b.D", 32'(c.D), 32'h1);
        chk("n1_b.WRAP", 32'(c.WRAP), 32'd1);
        step();
        chk("n1_c.D", 32'(c.D), 32'h2);
        chk("n1_c.WRAP", 32'(c.WRAP), 32'd0);
        step();
        chk("n1_d.IDX", 32'(c.IDX), 32'd0);
        chk("n1_d.WRAP", 32'(c.WRAP), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 SHALL provide parameter N, default 2, meaning select/index width; legal range 1..6; output width is 2**N.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port EN  input  1  enable; 0 forces outputs idle.
REQ-005 SHALL provide port MODE  input  1  0 = hold/decode, 1 = auto-scan.
REQ-006 SHALL provide port LD  input  1  load strobe; captures A into the index register.
REQ-007 SHALL provide port A  input  N  select/load value.
REQ-008 SHALL provide port D  output  2**N  registered one-hot decode of the current index.
REQ-009 SHALL provide port IDX  output  N  registered current index.
REQ-010 SHALL provide port VALID  output  1  registered; 1 when D carries a decoded value.
REQ-011 SHALL provide port WRAP  output  1  registered single-cycle pulse on scan wrap-around.

Function
REQ-012 SHALL hold an N-bit index register idx; IDX SHALL always equal idx.
REQ-013 SHALL implement three states: IDLE (EN=0), HOLD (EN=1, MODE=0), SCAN (EN=1, MODE=1); the state is re-evaluated every cycle from EN/MODE, with no extra transition cycles.
REQ-014 SHALL, in IDLE, drive D=0, VALID=0, WRAP=0 on the next edge and keep idx unchanged; LD SHALL be ignored while EN=0.
REQ-015 SHALL, when EN=1 and LD=1, load idx<=A regardless of MODE; LD has priority over the scan increment.
REQ-016 SHALL, in HOLD with LD=0, keep idx unchanged.
REQ-017 SHALL, in SCAN with LD=0, update idx<=(idx+1) mod 2**N every cycle.
REQ-018 SHALL, whenever EN=1, drive D on the next edge with exactly bit[next idx] set and all other bits clear, and drive VALID=1.
REQ-019 SHALL guarantee D is one-hot when VALID=1 and all-zero when VALID=0; no other encoding is legal.
REQ-020 SHALL have a latency of exactly one clock from inputs sampled at edge k to D/IDX/VALID/WRAP visible after edge k.
REQ-021 SHALL assert WRAP for exactly one cycle when a SCAN increment takes idx from 2**N-1 to 0; a load of 0 via LD SHALL NOT assert WRAP.
REQ-022 SHALL continue scanning from the loaded value on the cycle after an LD in SCAN mode: the loaded value appears for one cycle, then increments resume.
REQ-023 SHALL resume HOLD or SCAN from the retained idx when EN returns to 1 after IDLE.
REQ-024 SHALL, for N=1, toggle idx 0,1,0,... in SCAN and assert WRAP on every 1->0 step.
REQ-025 SHALL take an A containing X/Z only when LD=1; behaviour with unknown A under LD=1 is undefined, and A SHALL be don't-care otherwise.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force idx=0, D=0, IDX=0, VALID=0, WRAP=0, independent of clk.
REQ-027 SHALL, when rst_n asserts mid-scan, clear all outputs immediately; after release, the first edge with EN=1 and LD=0 SHALL yield D=0001 in HOLD and D=0010 in SCAN.
REQ-028 SHALL sample inputs normally from the first rising edge after rst_n deasserts.

Verification
REQ-029 SHALL cover reset then hold: N=2, release rst_n, EN=1, MODE=0, LD=1, A=2 for one cycle, then LD=0 -> D=0100, IDX=2, VALID=1 steady, WRAP=0.
REQ-030 SHALL cover the full scan: N=2, LD A=1, then MODE=1 for 4 cycles -> D sequence 0010,0100,1000,0001, with WRAP=1 only on the 0001 cycle.
REQ-031 SHALL cover enable drop: scanning at IDX=3, EN=0 for 2 cycles, then EN=1 with MODE=1 -> D=0, VALID=0 for 2 cycles, then D=0001, IDX=0, WRAP=1.
REQ-032 SHALL cover load priority: SCAN at IDX=1 with LD=1, A=3 -> next D=1000, IDX=3, WRAP=0; the following cycle D=0001, WRAP=1.
REQ-033 SHALL cover asynchronous reset mid-scan: rst_n low between edges at IDX=2 -> outputs go to 0 before the next edge, with no WRAP pulse.
REQ-034 SHALL cover N=3 sweep: 8-cycle scan from 0 -> D walks bit0..bit7, exactly one WRAP per 8 cycles, one-hot checked every cycle.
